cpu_fetch_sequencer: RTL and testbench



---
 rtl/cpu_fetch_pkg.sv | 10 +
 rtl/cpu_instr_length_lut.sv | 10 +
 rtl/cpu_fetch_sequencer.sv | 71 +++++++
 tb/tb_cpu_fetch_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared fetch FSM states, opcode constants and instruction length codes
package cpu_fetch_pkg;
  typedef enum logic [2:0] {S_RST, S_OPC, S_OPR1, S_OPR2, S_ISSUE, S_HALT} state_t;
  localparam logic [7:0] OP_HLT = 8'hF0;
  localparam logic [7:0] OP_LDA_IND = 8'h10;
  localparam logic [7:0] OP_STA_IND = 8'h20;
  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;
endpackage

// File: rtl/cpu_instr_length_lut.sv
// cpu_instr_length_lut: combinational opcode to instruction byte length (1..3)
module cpu_instr_length_lut
  import cpu_fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] length
);
  assign length = (opcode inside {OP_LDA_IND, OP_STA_IND, 8'hF8, 8'hF9, 8'hFA}) ? LEN_3 :
                  (opcode inside {8'h11, 8'h21, [8'hA0:8'hAF], 8'hC0, 8'hF1, 8'hF3}) ? LEN_2 : LEN_1;
endmodule

// File: rtl/cpu_fetch_sequencer.sv
// cpu_fetch_sequencer: byte-serial variable-length instruction fetch with redirect and halt
module cpu_fetch_sequencer
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [15:0]       instr_operand,
  output logic [1:0]        instr_length,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [7:0] opcode, byte1, byte2, lut_op;
  logic [1:0] len;
  logic take;
  assign lut_op = state == S_OPC ? mem_rdata : opcode;
  cpu_instr_length_lut u_lut (.opcode(lut_op), .length(len));
  assign take = mem_req && mem_ack && !redirect_valid;
  assign mem_req = state inside {S_OPC, S_OPR1, S_OPR2};
  assign mem_addr = pc + (state == S_OPR1 ? ADDR_W'(1) : state == S_OPR2 ? ADDR_W'(2) : ADDR_W'(0));
  assign instr_valid = state == S_ISSUE;
  assign instr_opcode = instr_valid ? opcode : 8'h00;
  assign instr_operand = !instr_valid ? 16'h0000 : len == LEN_3 ? {byte1, byte2} :
                         len == LEN_2 ? {8'h00, byte1} : 16'h0000;
  assign instr_length = instr_valid ? len : 2'd0;
  assign instr_pc = instr_valid ? pc : '0;
  assign halted = state == S_HALT;
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    if (state == S_RST) state_nx = S_OPC;
    else if (redirect_valid) begin
      state_nx = S_OPC;
      pc_nx = redirect_pc;
    end else if (take)
      state_nx = state == S_OPC ? (len == LEN_1 ? S_ISSUE : S_OPR1) :
                 state == S_OPR1 ? (len == LEN_2 ? S_ISSUE : S_OPR2) : S_ISSUE;
    else if (instr_valid && instr_ready) begin
      state_nx = opcode == OP_HLT ? S_HALT : S_OPC;
      pc_nx = pc + ADDR_W'(len);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
      pc <= RESET_PC;
      opcode <= 8'h00;
      byte1 <= 8'h00;
      byte2 <= 8'h00;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      opcode <= take && state == S_OPC ? mem_rdata : opcode;
      byte1 <= take && state == S_OPR1 ? mem_rdata : byte1;
      byte2 <= take && state == S_OPR2 ? mem_rdata : byte2;
    end
  end
endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// tb_cpu_fetch_sequencer: directed self-checking bench for the fetch sequencer
module tb_cpu_fetch_sequencer;
  logic clk = 0, rst_n = 0, rst8_n = 0;
  logic mem_req, mem_ack, redirect_valid = 0, instr_valid, instr_ready = 0, halted;
  logic [15:0] mem_addr, redirect_pc = 0, instr_pc, instr_operand;
  logic [7:0] mem_rdata, instr_opcode;
  logic [1:0] instr_length;
  logic req8, ack8, valid8, ready8 = 0, halted8, r8_valid = 0;
  logic [7:0] addr8, r8_pc = 0, pc8, opc8, rdata8;
  logic [15:0] operand8;
  logic [1:0] len8;
  logic [7:0] mem [0:255];
  logic [7:0] mem8 [0:255];
  int wcnt = 0, wait_n = 0, n_chk = 0, n_fail = 0, n;
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_ack = mem_req && (wcnt >= wait_n);
  always @(posedge clk) wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
  assign rdata8 = mem8[addr8];
  assign ack8 = req8;
  cpu_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_operand(instr_operand), .instr_length(instr_length), .instr_pc(instr_pc), .halted(halted)
  );
  cpu_fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'hFE)) dut8 (
    .clk(clk), .rst_n(rst8_n), .mem_req(req8), .mem_addr(addr8), .mem_rdata(rdata8),
    .mem_ack(ack8), .redirect_valid(r8_valid), .redirect_pc(r8_pc),
    .instr_valid(valid8), .instr_ready(ready8), .instr_opcode(opc8),
    .instr_operand(operand8), .instr_length(len8), .instr_pc(pc8), .halted(halted8)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_valid"}, 32'(instr_valid), 0);
    chk({tag, "_opc"}, 32'(instr_opcode), 0);
    chk({tag, "_opr"}, 32'(instr_operand), 0);
    chk({tag, "_len"}, 32'(instr_length), 0);
    chk({tag, "_pc"}, 32'(instr_pc), 0);
    chk({tag, "_halt"}, 32'(halted), 0);
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!instr_valid && cyc < 30) begin
      step();
      cyc++;
    end
  endtask
  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    foreach (mem8[i]) mem8[i] = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'hA7; mem[2] = 8'h55; mem[3] = 8'hF0;
    mem[8'h20] = 8'h10; mem[8'h21] = 8'h12; mem[8'h22] = 8'h34;
    mem[8'h23] = 8'h11; mem[8'h24] = 8'h99;
    mem[8'h40] = 8'h00;
    mem[8'h41] = 8'h20; mem[8'h42] = 8'hAB; mem[8'h43] = 8'hCD;
    mem8[8'hFE] = 8'hF9; mem8[8'hFF] = 8'h12; mem8[8'h00] = 8'h34;
    step();
    step();
    chk_reset("rst");
    rst_n = 1;
    step();
    chk("c1_req", 32'(mem_req), 1);
    chk("c1_addr", 32'(mem_addr), 0);
    step();
    chk("i1_valid", 32'(instr_valid), 1);
    chk("i1_opc", 32'(instr_opcode), 32'h01);
    chk("i1_len", 32'(instr_length), 1);
    chk("i1_pc", 32'(instr_pc), 0);
    chk("i1_opr", 32'(instr_operand), 0);
    chk("i1_noreq", 32'(mem_req), 0);
    instr_ready = 1;
    step();
    instr_ready = 0;
    chk("i2_addr0", 32'(mem_addr), 1);
    chk("i2_valid0", 32'(instr_valid), 0);
    step();
    chk("i2_addr1", 32'(mem_addr), 2);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("i2_valid", 32'(instr_valid), 1);
      chk("i2_opc", 32'(instr_opcode), 32'hA7);
      chk("i2_opr", 32'(instr_operand), 32'h0055);
      chk("i2_len", 32'(instr_length), 2);
      chk("i2_pc", 32'(instr_pc), 1);
      chk("i2_noreq", 32'(mem_req), 0);
      if (k < 4) step();
    end
    instr_ready = 1;
    step();
    instr_ready = 0;
    chk("h_addr", 32'(mem_addr), 3);
    step();
    chk("h_opc", 32'(instr_opcode), 32'hF0);
    chk("h_len", 32'(instr_length), 1);
    instr_ready = 1;
    step();
    instr_ready = 0;
    for (int k = 0; k < 10; k++) begin
      chk("h_halted", 32'(halted), 1);
      chk("h_noreq", 32'(mem_req), 0);
      step();
    end
    wait_n = 2;
    redirect_valid = 1;
    redirect_pc = 16'h0020;
    step();
    redirect_valid = 0;
    chk("r_halted", 32'(halted), 0);
    chk("r_req", 32'(mem_req), 1);
    chk("r_addr", 32'(mem_addr), 32'h20);
    wait_valid(n);
    chk("w_cycles", 32'(n), 9);
    chk("w_opc", 32'(instr_opcode), 32'h10);
    chk("w_opr", 32'(instr_operand), 32'h1234);
    chk("w_len", 32'(instr_length), 3);
    chk("w_pc", 32'(instr_pc), 32'h20);
    instr_ready = 1;
    step();
    instr_ready = 0;
    wait_n = 0;
    chk("w_next", 32'(mem_addr), 32'h23);
    step();
    chk("d_addr", 32'(mem_addr), 32'h24);
    chk("d_ack", 32'(mem_ack), 1);
    redirect_valid = 1;
    redirect_pc = 16'h0040;
    step();
    redirect_valid = 0;
    chk("d_raddr", 32'(mem_addr), 32'h40);
    chk("d_valid", 32'(instr_valid), 0);
    step();
    chk("d_opc", 32'(instr_opcode), 32'h00);
    chk("d_pc", 32'(instr_pc), 32'h40);
    chk("d_len", 32'(instr_length), 1);
    instr_ready = 1;
    step();
    instr_ready = 0;
    step();
    step();
    chk("a_addr", 32'(mem_addr), 32'h43);
    rst_n = 0;
    #1;
    chk_reset("arst");
    step();
    rst8_n = 1;
    step();
    chk("e_a0", 32'(addr8), 32'hFE);
    step();
    chk("e_a1", 32'(addr8), 32'hFF);
    step();
    chk("e_a2", 32'(addr8), 32'h00);
    step();
    chk("e_valid", 32'(valid8), 1);
    chk("e_opr", 32'(operand8), 32'h1234);
    chk("e_len", 32'(len8), 3);
    chk("e_pc", 32'(pc8), 32'hFE);
    ready8 = 1;
    step();
    ready8 = 0;
    chk("e_next", 32'(addr8), 32'h01);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
